scanline_fetcher: RTL and testbench

Framebuffer-to-pixel stage that sits between the VGA timing driver and the frame display/colour output. It prefetches one 320-pixel framebuffer row at a time from a read-only memory port into a double-buffered line store, then serves 6:6:6 RGB pixels at 2x horizontal and 2x vertical scale. Pixels come from the driver's `vga_x`, `vga_y`, `active` and `vblank` outputs, with one cycle of latency.

---
 rtl/video_pkg.sv | 20 ++
 rtl/scanline_ram.sv | 33 +++
 rtl/scanline_fetcher.sv | 194 +++++++++++++++++++
 tb/tb_scanline_fetcher.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// ============================================================================
// video_pkg: shared framebuffer geometry, pixel widths and fetch FSM states.
// Rev 1.0
// ============================================================================
`default_nettype none

package video_pkg;
   localparam int FB_W_DFLT = 320;
   localparam int FB_H_DFLT = 240;
   localparam int PIX_W     = 18;
   localparam int CH_W      = 6;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } fetch_state_t;
endpackage

`default_nettype wire

// File: rtl/scanline_ram.sv
// ============================================================================
// scanline_ram: one line-store bank, single write port and registered read.
// Rev 1.0
// ============================================================================
`default_nettype none

module scanline_ram
   import video_pkg::*;
#(
   parameter int DEPTH   = FB_W_DFLT,
   parameter int ADDR_AW = $clog2(DEPTH)
) (
   input  logic               clock,
   input  logic               wr_en,
   input  logic [ADDR_AW-1:0] wr_addr,
   input  logic [PIX_W-1:0]   wr_data,
   input  logic [ADDR_AW-1:0] rd_addr,
   output logic [PIX_W-1:0]   rd_data
);

   logic [PIX_W-1:0] mem [DEPTH];

   // No reset: contents are only trusted once the owning bank is marked valid.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      rd_data <= mem[rd_addr];
   end

endmodule

`default_nettype wire

// File: rtl/scanline_fetcher.sv
// ============================================================================
// scanline_fetcher: prefetches framebuffer rows into a double-buffered line
// store and serves 2x-scaled 6:6:6 pixels one cycle after the VGA inputs. Rev 1.0
// ============================================================================
`default_nettype none

module scanline_fetcher
   import video_pkg::*;
#(
   parameter int FB_W    = FB_W_DFLT,
   parameter int FB_H    = FB_H_DFLT,
   parameter int ADDR_W  = 17,
   parameter int FB_BASE = 0,
   parameter int MAX_OUT = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [9:0]        in_pix_x,
   input  logic [9:0]        in_pix_y,
   input  logic              in_pix_active,
   input  logic              in_pix_vblank,
   output logic [CH_W-1:0]   out_pix_red,
   output logic [CH_W-1:0]   out_pix_green,
   output logic [CH_W-1:0]   out_pix_blue,
   output logic              out_pix_active,
   output logic              out_underrun,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ready,
   input  logic              mem_rvalid,
   input  logic [PIX_W-1:0]  mem_rdata
);

   localparam int                LINE_AW  = $clog2(FB_W);
   localparam int                CNT_W    = 9;
   localparam logic [CNT_W-1:0]  ROW_LEN  = CNT_W'(FB_W);
   localparam logic [ADDR_W-1:0] BASE0    = ADDR_W'(FB_BASE);
   localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(FB_W);
   localparam logic [3:0]        OUT_LIM  = 4'(MAX_OUT);
   localparam logic [9:0]        ROWS     = 10'(FB_H);

   fetch_state_t      state, state_nxt;
   logic              vblank_d, active_d;
   logic [9:0]        line_y;
   logic [9:0]        fall_row;
   logic [ADDR_W-1:0] next_base;
   logic [CNT_W-1:0]  issued, issued_nxt;
   logic [CNT_W-1:0]  received, received_nxt;
   logic [3:0]        outstanding, outstanding_nxt;
   logic [ADDR_W-1:0] addr_nxt;
   logic              req_nxt;
   logic [1:0]        bank_valid, valid_nxt;
   logic              tgt_bank, bank_nxt;
   logic              vblank_rise, fall_fetch, trigger, trig_bank;
   logic [ADDR_W-1:0] trig_base;
   logic              accept, rsp, ram_we, trig_busy;
   logic              disp_bank, show, starve;
   logic              show_q, sel_q;
   logic [LINE_AW-1:0] rd_addr;
   logic [PIX_W-1:0]  bank_rd [2];
   logic [PIX_W-1:0]  pix;
   logic              unused_ok;

   assign vblank_rise = in_pix_vblank & ~vblank_d;
   assign fall_row    = {1'b0, line_y[9:1]} + 10'd1;
   assign fall_fetch  = ~in_pix_active & active_d & ~line_y[0] & (fall_row < ROWS);
   assign trigger     = vblank_rise | fall_fetch;
   assign trig_bank   = vblank_rise ? 1'b0 : fall_row[0];
   // Rows are fetched in order each frame, so the row base advances by FB_W
   // on every even-line trigger instead of being multiplied out.
   assign trig_base   = vblank_rise ? BASE0 : next_base;

   always_comb begin
      state_nxt       = state;
      issued_nxt      = issued;
      received_nxt    = received;
      outstanding_nxt = outstanding;
      addr_nxt        = mem_addr;
      valid_nxt       = bank_valid;
      bank_nxt        = tgt_bank;
      accept          = mem_req & mem_ready;
      rsp             = mem_rvalid & (state != IDLE) & (received < ROW_LEN);
      ram_we          = rsp;
      trig_busy       = trigger & (state != IDLE);

      if (rsp) begin
         received_nxt = received + 1'b1;
      end

      case (state)
         IDLE: begin
            if (trigger) begin
               state_nxt            = ISSUE;
               valid_nxt[trig_bank] = 1'b0;
               bank_nxt             = trig_bank;
               issued_nxt           = '0;
               received_nxt         = '0;
               outstanding_nxt      = '0;
               addr_nxt             = trig_base;
            end
         end
         ISSUE: begin
            if (accept) begin
               issued_nxt = issued + 1'b1;
               addr_nxt   = mem_addr + 1'b1;
            end
            outstanding_nxt = outstanding + 4'(accept) - 4'(rsp);
            if (issued_nxt == ROW_LEN) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            outstanding_nxt = outstanding - 4'(rsp);
            if (received == ROW_LEN) begin
               valid_nxt[tgt_bank] = 1'b1;
               state_nxt           = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase

      req_nxt = (state_nxt == ISSUE) && (issued_nxt < ROW_LEN) && (outstanding_nxt < OUT_LIM);
   end

   assign disp_bank = in_pix_y[1];
   assign show      = in_pix_active & bank_valid[disp_bank];
   assign starve    = in_pix_active & ~bank_valid[disp_bank];
   assign rd_addr   = LINE_AW'(in_pix_x >> 1);
   assign unused_ok = in_pix_x[0];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state          <= IDLE;
         vblank_d       <= 1'b0;
         active_d       <= 1'b0;
         line_y         <= '0;
         next_base      <= '0;
         issued         <= '0;
         received       <= '0;
         outstanding    <= '0;
         mem_req        <= 1'b0;
         mem_addr       <= '0;
         bank_valid     <= '0;
         tgt_bank       <= 1'b0;
         out_underrun   <= 1'b0;
         out_pix_active <= 1'b0;
         show_q         <= 1'b0;
         sel_q          <= 1'b0;
      end else begin
         state          <= state_nxt;
         vblank_d       <= in_pix_vblank;
         active_d       <= in_pix_active;
         issued         <= issued_nxt;
         received       <= received_nxt;
         outstanding    <= outstanding_nxt;
         mem_req        <= req_nxt;
         mem_addr       <= addr_nxt;
         bank_valid     <= valid_nxt;
         tgt_bank       <= bank_nxt;
         out_pix_active <= in_pix_active;
         show_q         <= show;
         sel_q          <= disp_bank;
         if (in_pix_active) begin
            line_y <= in_pix_y;
         end
         if (vblank_rise) begin
            next_base <= BASE0 + ROW_STEP;
         end else if (fall_fetch) begin
            next_base <= next_base + ROW_STEP;
         end
         // A fresh underrun in the clearing cycle wins over the vblank clear.
         out_underrun <= starve | trig_busy | (out_underrun & ~vblank_rise);
      end
   end

   for (genvar b = 0; b < 2; b++) begin : g_bank
      scanline_ram #(.DEPTH(FB_W)) u_ram (
         .clock   (clock),
         .wr_en   (ram_we & (tgt_bank == 1'(b))),
         .wr_addr (received[LINE_AW-1:0]),
         .wr_data (mem_rdata),
         .rd_addr (rd_addr),
         .rd_data (bank_rd[b])
      );
   end

   assign pix           = sel_q ? bank_rd[1] : bank_rd[0];
   assign out_pix_red   = show_q ? pix[17:12] : '0;
   assign out_pix_green = show_q ? pix[11:6]  : '0;
   assign out_pix_blue  = show_q ? pix[5:0]   : '0;

endmodule

`default_nettype wire

// File: tb/tb_scanline_fetcher.sv
// ============================================================================
// tb_scanline_fetcher: randomized memory + scaled VGA raster against a
// framebuffer-arithmetic pixel model. Rev 1.0
// ============================================================================
`default_nettype none

module tb_scanline_fetcher;

   localparam int FB_W    = 16;
   localparam int FB_H    = 6;
   localparam int ADDR_W  = 17;
   localparam int FB_BASE = 131040;   // rows 2+ wrap past 2^17
   localparam int MAX_OUT = 4;
   localparam int H_ACT   = 2 * FB_W;
   localparam int H_TOT   = H_ACT + 100;
   localparam int V_ACT   = 2 * FB_H;
   localparam int V_TOT   = V_ACT + 4;

   logic              clock = 1'b0;
   logic              reset;
   logic [9:0]        in_pix_x, in_pix_y;
   logic              in_pix_active, in_pix_vblank;
   logic [5:0]        out_pix_red, out_pix_green, out_pix_blue;
   logic              out_pix_active, out_underrun;
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ready, mem_rvalid;
   logic [17:0]       mem_rdata;

   always #5 clock = ~clock;

   scanline_fetcher #(
      .FB_W(FB_W), .FB_H(FB_H), .ADDR_W(ADDR_W), .FB_BASE(FB_BASE), .MAX_OUT(MAX_OUT)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .in_pix_x       (in_pix_x),
      .in_pix_y       (in_pix_y),
      .in_pix_active  (in_pix_active),
      .in_pix_vblank  (in_pix_vblank),
      .out_pix_red    (out_pix_red),
      .out_pix_green  (out_pix_green),
      .out_pix_blue   (out_pix_blue),
      .out_pix_active (out_pix_active),
      .out_underrun   (out_underrun),
      .mem_req        (mem_req),
      .mem_addr       (mem_addr),
      .mem_ready      (mem_ready),
      .mem_rvalid     (mem_rvalid),
      .mem_rdata      (mem_rdata)
   );

   int n_cmp = 0, n_mis = 0;

   logic [17:0] rq[$];
   int          dq[$];
   int          cyc = 0, last_due = 0, acc_n = 0, rsp_n = 0, peak = 0;
   int          ready_pct = 100, lat_max = 1;
   bit          stall = 0, want_first = 0, hold_chk = 0;
   logic [ADDR_W-1:0] held;
   bit          p_act = 0;
   int          p_x = 0, p_y = 0, p_mode = 0, p_urn = -1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_mis++;
         $display("FAIL %s @cyc %0d: got %0h want %0h", tag, cyc, got, want);
      end
   endtask

   // Framebuffer word at (x,y) of the 2x-scaled raster; memory returns its address.
   function automatic logic [17:0] model_pix(input int x, input int y);
      int a;
      a = (FB_BASE + (y / 2) * FB_W + (x / 2)) % (1 << ADDR_W);
      return 18'(a);
   endfunction

   // mode: 0 no pixel check, 1 model pixel, 2 forced black; urn: -1 skip, else expected flag
   task automatic step(input bit act, input int x, input int y, input bit vb,
                       input int mode, input int urn);
      logic [17:0] rgb;
      bit rdy;
      int lat, due, outst;
      @(negedge clock);
      cyc++;
      rgb   = {out_pix_red, out_pix_green, out_pix_blue};
      outst = acc_n - rsp_n;
      if (outst > peak) peak = outst;
      if (p_mode != 0) begin
         check("pix", rgb, (p_mode == 1 && p_act) ? model_pix(p_x, p_y) : 18'd0);
         check("pix_active", out_pix_active, p_act);
      end
      if (p_urn >= 0) check("underrun", out_underrun, p_urn[0]);
      if (hold_chk) check("addr_hold", mem_addr, held);
      if (mem_req) check("req_below_max", outst < MAX_OUT, 1);

      rdy      = !stall && ($urandom_range(99) < ready_pct);
      hold_chk = mem_req && !rdy;
      held     = mem_addr;
      if (mem_req && rdy) begin
         if (want_first) begin
            check("first_addr", mem_addr, FB_BASE);
            want_first = 0;
         end
         lat = $urandom_range(lat_max, 1);
         due = cyc + lat;
         if (due <= last_due) due = last_due + 1;
         last_due = due;
         rq.push_back(18'(mem_addr));
         dq.push_back(due);
         acc_n++;
      end
      mem_ready = rdy;
      if (rq.size() > 0 && dq[0] <= cyc) begin
         mem_rvalid = 1'b1;
         mem_rdata  = rq.pop_front();
         void'(dq.pop_front());
         rsp_n++;
      end else begin
         mem_rvalid = 1'b0;
         mem_rdata  = 18'($urandom);
      end

      in_pix_active = act;
      in_pix_x      = 10'(x);
      in_pix_y      = 10'(y);
      in_pix_vblank = vb;
      p_act = act; p_x = x; p_y = y; p_mode = mode; p_urn = urn;
   endtask

   // One frame starting at the blanking lines; mode 1 starves the row fetched after line 6.
   task automatic run_frame(input int mode);
      for (int l = 0; l < V_TOT; l++) begin
         int ln;
         ln = (l + V_ACT) % V_TOT;
         for (int h = 0; h < H_TOT; h++) begin
            bit act;
            int pm, uw;
            act = (ln < V_ACT) && (h < H_ACT);
            pm  = 1;
            uw  = 0;
            if (mode == 1) begin
               stall = (ln >= 6 && ln < V_ACT - 1) || (ln == V_ACT - 1 && h < H_ACT);
               if (ln == 8 || ln == 9) pm = 2;
               else if (ln >= 10 && ln < V_ACT) pm = 0;
               if (ln >= 8 && ln < V_ACT) uw = 1;
            end
            step(act, act ? h : 0, act ? ln : 0, ln >= V_ACT, pm, uw);
         end
      end
      stall = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc0, k;
      reset = 1'b0;
      in_pix_x = '0; in_pix_y = '0; in_pix_active = 1'b0; in_pix_vblank = 1'b0;
      mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

      repeat (10) begin
         @(negedge clock);
         check("rst_req", mem_req, 0);
         check("rst_rgb", {out_pix_red, out_pix_green, out_pix_blue}, 0);
         check("rst_active", out_pix_active, 0);
         check("rst_underrun", out_underrun, 0);
      end
      reset = 1'b1;

      repeat (8) begin
         step(0, 0, 0, 0, 1, 0);
         check("idle_req", mem_req, 0);
      end

      ready_pct = 100; lat_max = 1; want_first = 1;
      run_frame(0);

      ready_pct = 50; lat_max = 20;
      run_frame(0);
      run_frame(0);
      check("outst_peak", peak, MAX_OUT);

      ready_pct = 100; lat_max = 1;
      run_frame(1);
      run_frame(0);

      // Abort a row-0 fetch halfway through its issue phase.
      acc0 = acc_n;
      k = 0;
      while (acc_n - acc0 < FB_W / 2 && k < 2000) begin
         step(0, 0, 0, 1, 1, 0);
         k++;
      end
      check("mid_fetch_reached", (acc_n - acc0) >= FB_W / 2, 1);
      @(posedge clock);
      #1;
      check("pre_rst_req", mem_req, 1);
      #1;
      reset = 1'b0;
      #1;
      check("async_rst_req", mem_req, 0);
      check("async_rst_addr", mem_addr, 0);
      check("async_rst_underrun", out_underrun, 0);
      mem_ready = 1'b0; mem_rvalid = 1'b0;
      in_pix_vblank = 1'b0; in_pix_active = 1'b0;
      rq.delete(); dq.delete();
      acc_n = 0; rsp_n = 0; last_due = 0; hold_chk = 0;
      p_mode = 0; p_urn = -1;
      repeat (3) @(negedge clock);
      reset = 1'b1;
      repeat (4) begin
         step(0, 0, 0, 0, 1, 0);
         check("post_rst_idle_req", mem_req, 0);
      end
      want_first = 1;
      run_frame(0);
      check("refetch_seen", want_first, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

`default_nettype wire
